// File: rtl/hbridge_pkg.sv
// Shared types and default timing constants for the H-bridge driver and its dead-time legs.
package hbridge_pkg;

    localparam int DEAD_CYCLES_DEF   = 8;
    localparam int SWITCH_CYCLES_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POS  = 2'd1,
        NEG  = 2'd2,
        REV  = 2'd3
    } bridge_state_t;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        HI_ON = 2'd1,
        LO_ON = 2'd2,
        DEAD  = 2'd3
    } leg_state_t;

    typedef struct packed {
        bridge_state_t bridge;
        leg_state_t    leg_a;
        leg_state_t    leg_b;
    } dbg_t;

endpackage

// File: rtl/halfbridge_leg.sv
// One half-bridge leg: turns the requested FET on only after DEAD_CYCLES cycles with both FETs off.
module halfbridge_leg
    import hbridge_pkg::*;
#(
    parameter int DEAD_CYCLES = DEAD_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run_i,
    input  logic       req_hi_i,
    output logic       hi_o,
    output logic       lo_o,
    output leg_state_t state_o
);

    localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CYCLES);

    leg_state_t state_q;
    logic [7:0] cnt_q;
    logic [7:0] cnt_dec;
    logic       hi_q;
    logic       lo_q;

    // Counter parks at zero instead of wrapping.
    assign cnt_dec = (cnt_q != 8'd0) ? (cnt_q - 8'd1) : 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OFF;
            cnt_q   <= 8'd0;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
        end else if (!run_i) begin
            state_q <= OFF;
            cnt_q   <= 8'd0;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
        end else begin
            case (state_q)
                OFF: begin
                    state_q <= DEAD;
                    cnt_q   <= DEAD_LOAD;
                    hi_q    <= 1'b0;
                    lo_q    <= 1'b0;
                end
                HI_ON: begin
                    if (!req_hi_i) begin
                        state_q <= DEAD;
                        cnt_q   <= DEAD_LOAD;
                        hi_q    <= 1'b0;
                    end
                end
                LO_ON: begin
                    if (req_hi_i) begin
                        state_q <= DEAD;
                        cnt_q   <= DEAD_LOAD;
                        lo_q    <= 1'b0;
                    end
                end
                DEAD: begin
                    // The side to switch on is whatever is requested when the count runs out.
                    cnt_q <= cnt_dec;
                    if (cnt_dec == 8'd0) begin
                        state_q <= req_hi_i ? HI_ON : LO_ON;
                        hi_q    <= req_hi_i;
                        lo_q    <= ~req_hi_i;
                    end
                end
                default: begin
                    state_q <= OFF;
                    cnt_q   <= 8'd0;
                    hi_q    <= 1'b0;
                    lo_q    <= 1'b0;
                end
            endcase
        end
    end

    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
    assign state_o = state_q;

endmodule

// File: rtl/hbridge_driver.sv
// H-bridge driver: registered inputs, IDLE/POS/NEG/REV sequencing and two dead-time legs.
// Define FAULT_LATCH_EN to latch faults until clearFault; otherwise faulted follows faultN.
module hbridge_driver
    import hbridge_pkg::*;
#(
    parameter int DEAD_CYCLES   = DEAD_CYCLES_DEF,
    parameter int SWITCH_CYCLES = SWITCH_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic signIn,
    input  logic carrierIn,
    input  logic faultN,
    input  logic clearFault,
    output logic hiA,
    output logic loA,
    output logic hiB,
    output logic loB,
    output logic faulted,
    output dbg_t dbg_o
);

    localparam logic [7:0] SWITCH_LOAD = 8'(SWITCH_CYCLES);

    logic          enable_q;
    logic          sign_q;
    logic          carrier_q;
    logic          fault_q;
    logic          fault_act;
    bridge_state_t state_q;
    bridge_state_t state_d;
    logic [7:0]    rev_cnt_q;
    logic [7:0]    rev_dec;
    logic          leg_run;
    logic          req_hi_a;
    logic          req_hi_b;
    leg_state_t    leg_a_state;
    leg_state_t    leg_b_state;

    // faultN is kept inverted so every input register clears to 0 on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable_q  <= 1'b0;
            sign_q    <= 1'b0;
            carrier_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            enable_q  <= enable;
            sign_q    <= signIn;
            carrier_q <= carrierIn;
            fault_q   <= ~faultN;
        end
    end

`ifdef FAULT_LATCH_EN
    logic latch_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            latch_q <= 1'b0;
        end else if (fault_q) begin
            latch_q <= 1'b1;
        end else if (clearFault) begin
            latch_q <= 1'b0;
        end
    end

    assign fault_act = fault_q | latch_q;
    assign faulted   = latch_q;
`else
    logic unused_clear;

    assign unused_clear = clearFault;
    assign fault_act    = fault_q;
    assign faulted      = fault_q;
`endif

    assign rev_dec = (rev_cnt_q != 8'd0) ? (rev_cnt_q - 8'd1) : 8'd0;

    always_comb begin
        state_d = state_q;
        if (!enable_q || fault_act) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = sign_q ? NEG : POS;
                POS:     if (sign_q)  state_d = REV;
                NEG:     if (!sign_q) state_d = REV;
                REV:     if (rev_dec == 8'd0) state_d = sign_q ? NEG : POS;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rev_cnt_q <= 8'd0;
        end else begin
            state_q <= state_d;
            if (state_d == REV) begin
                rev_cnt_q <= (state_q == REV) ? rev_dec : SWITCH_LOAD;
            end else begin
                rev_cnt_q <= 8'd0;
            end
        end
    end

    // Legs follow the next state so gates drop on the same edge the bridge leaves POS/NEG.
    assign leg_run  = (state_d == POS) || (state_d == NEG);
    assign req_hi_a = (state_d == POS) && carrier_q;
    assign req_hi_b = (state_d == NEG) && carrier_q;

    halfbridge_leg #(.DEAD_CYCLES(DEAD_CYCLES)) u_leg_a (
        .clk      (clk),
        .rst_n    (reset),
        .run_i    (leg_run),
        .req_hi_i (req_hi_a),
        .hi_o     (hiA),
        .lo_o     (loA),
        .state_o  (leg_a_state)
    );

    halfbridge_leg #(.DEAD_CYCLES(DEAD_CYCLES)) u_leg_b (
        .clk      (clk),
        .rst_n    (reset),
        .run_i    (leg_run),
        .req_hi_i (req_hi_b),
        .hi_o     (hiB),
        .lo_o     (loB),
        .state_o  (leg_b_state)
    );

    assign dbg_o.bridge = state_q;
    assign dbg_o.leg_a  = leg_a_state;
    assign dbg_o.leg_b  = leg_b_state;

endmodule
